// File: rtl/pid_move_sequencer_if.sv
// Handshake bundle between cmd_proc, the move sequencer and the PID steering block.
// The master side issues move requests and heading samples. The slave side is the sequencer.
interface pid_move_sequencer_if;
    logic        move_go;
    logic        move_stop;
    logic        err_vld_in;
    logic [11:0] error_in;
    logic        moving;
    logic        err_vld;
    logic [9:0]  frwrd;
    logic        busy;
    logic        done;

    modport master (
        output move_go, move_stop, err_vld_in, error_in,
        input  moving, err_vld, frwrd, busy, done
    );

    modport slave (
        input  move_go, move_stop, err_vld_in, error_in,
        output moving, err_vld, frwrd, busy, done
    );
endinterface

// File: rtl/pid_move_sequencer.sv
// Move sequencer: spin to align the heading, ramp forward speed up to a cap, cruise,
// then ramp down on stop. Forward speed changes by one step per valid heading sample.
module pid_move_sequencer #(
    parameter logic [9:0]  FRWRD_MAX = 10'h300,
    parameter logic [9:0]  INC       = 10'h010,
    parameter logic [9:0]  DEC       = 10'h020,
    parameter logic [11:0] ALIGN_THR = 12'd32
) (
    input  logic                 clk,
    input  logic                 rst,
    pid_move_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, ALIGN, RAMP_UP, CRUISE, RAMP_DN} state_t;

    state_t      state, state_nxt;
    logic [9:0]  frwrd_q, frwrd_nxt;
    logic        done_q, done_nxt;
    logic [12:0] err_mag;
    logic        aligned;
    logic [10:0] up_sum;
    logic [9:0]  up_val;
    logic [9:0]  dn_val;

    // The 13-bit magnitude keeps -2048 as +2048, so it can never count as aligned.
    assign err_mag = bus.error_in[11] ? (13'd0 - {1'b1, bus.error_in}) : {1'b0, bus.error_in};
    assign aligned = err_mag < {1'b0, ALIGN_THR};
    assign up_sum  = {1'b0, frwrd_q} + {1'b0, INC};
    assign up_val  = (up_sum >= {1'b0, FRWRD_MAX}) ? FRWRD_MAX : up_sum[9:0];
    assign dn_val  = (frwrd_q <= DEC) ? 10'd0 : frwrd_q - DEC;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            frwrd_q <= 10'd0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            frwrd_q <= frwrd_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_nxt = state;
        frwrd_nxt = frwrd_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                frwrd_nxt = 10'd0;
                if (bus.move_go) state_nxt = ALIGN;
            end
            ALIGN: begin
                frwrd_nxt = 10'd0;
                if (bus.move_stop)                    state_nxt = RAMP_DN;
                else if (bus.err_vld_in && aligned)   state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                if (bus.move_stop) begin
                    state_nxt = RAMP_DN;
                end else if (bus.err_vld_in) begin
                    frwrd_nxt = up_val;
                    if (up_val == FRWRD_MAX) state_nxt = CRUISE;
                end
            end
            CRUISE: begin
                frwrd_nxt = FRWRD_MAX;
                if (bus.move_stop) state_nxt = RAMP_DN;
            end
            RAMP_DN: begin
                if (frwrd_q == 10'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (bus.err_vld_in) begin
                    frwrd_nxt = dn_val;
                end
            end
            default: begin
                state_nxt = IDLE;
                frwrd_nxt = 10'd0;
            end
        endcase
    end

    always_comb begin
        bus.moving  = (state != IDLE);
        bus.busy    = (state != IDLE);
        bus.err_vld = bus.err_vld_in && (state != IDLE);
        bus.frwrd   = frwrd_q;
        bus.done    = done_q;
    end

endmodule

// File: tb/tb_pid_move_sequencer.sv
// Randomized and directed bench for pid_move_sequencer. Two instances (default cap and 0x305 cap)
// share the stimulus and are compared every cycle against a behavioural model of the move rules.
module tb_pid_move_sequencer;

    logic clk = 1'b0;
    logic rst;

    pid_move_sequencer_if bus0();
    pid_move_sequencer_if bus1();

    pid_move_sequencer u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pid_move_sequencer #(.FRWRD_MAX(10'h305)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    localparam int P_IDLE   = 0;
    localparam int P_ALIGN  = 1;
    localparam int P_UP     = 2;
    localparam int P_CRUISE = 3;
    localparam int P_DOWN   = 4;

    int n_vec    = 0;
    int n_miscmp = 0;

    int m_ph[2];
    int m_f[2];
    int m_done[2];
    int cap[2] = '{'h300, 'h305};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i]   = P_IDLE;
            m_f[i]    = 0;
            m_done[i] = 0;
        end
    endfunction

    // One clock of the move rules, written directly from the behavioural description.
    function automatic void model_step(input int i, input bit go, input bit stop,
                                       input bit vld, input logic [11:0] err);
        int e;
        int mag;
        e   = $signed(err);
        mag = (e < 0) ? -e : e;
        m_done[i] = 0;
        case (m_ph[i])
            P_IDLE:   if (go) m_ph[i] = P_ALIGN;
            P_ALIGN: begin
                if (stop)                 m_ph[i] = P_DOWN;
                else if (vld && mag < 32) m_ph[i] = P_UP;
            end
            P_UP: begin
                if (stop) m_ph[i] = P_DOWN;
                else if (vld) begin
                    m_f[i] = (m_f[i] + 16 > cap[i]) ? cap[i] : m_f[i] + 16;
                    if (m_f[i] == cap[i]) m_ph[i] = P_CRUISE;
                end
            end
            P_CRUISE: if (stop) m_ph[i] = P_DOWN;
            default: begin
                if (m_f[i] == 0) begin
                    m_ph[i]   = P_IDLE;
                    m_done[i] = 1;
                end else if (vld) begin
                    m_f[i] = (m_f[i] > 32) ? m_f[i] - 32 : 0;
                end
            end
        endcase
    endfunction

    task automatic compare_all();
        check("frwrd0",  32'(bus0.frwrd),  32'(m_f[0]));
        check("moving0", 32'(bus0.moving), 32'(m_ph[0] != P_IDLE));
        check("busy0",   32'(bus0.busy),   32'(m_ph[0] != P_IDLE));
        check("done0",   32'(bus0.done),   32'(m_done[0]));
        check("frwrd1",  32'(bus1.frwrd),  32'(m_f[1]));
        check("moving1", 32'(bus1.moving), 32'(m_ph[1] != P_IDLE));
        check("busy1",   32'(bus1.busy),   32'(m_ph[1] != P_IDLE));
        check("done1",   32'(bus1.done),   32'(m_done[1]));
    endtask

    task automatic drive(input bit go, input bit stop, input bit vld, input logic [11:0] err);
        bus0.move_go = go;  bus0.move_stop = stop;  bus0.err_vld_in = vld;  bus0.error_in = err;
        bus1.move_go = go;  bus1.move_stop = stop;  bus1.err_vld_in = vld;  bus1.error_in = err;
    endtask

    // Apply one cycle of stimulus, check err_vld combinationally, then check registered outputs.
    task automatic apply(input bit go, input bit stop, input bit vld, input logic [11:0] err);
        drive(go, stop, vld, err);
        #1;
        check("err_vld0", 32'(bus0.err_vld), 32'(vld && m_ph[0] != P_IDLE));
        check("err_vld1", 32'(bus1.err_vld), 32'(vld && m_ph[1] != P_IDLE));
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, go, stop, vld, err);
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_frwrd"},  32'(bus0.frwrd),  32'd0);
        check({tag, "_moving"}, 32'(bus0.moving), 32'd0);
        check({tag, "_busy"},   32'(bus0.busy),   32'd0);
        check({tag, "_done"},   32'(bus0.done),   32'd0);
        check({tag, "_frwrd1"}, 32'(bus1.frwrd),  32'd0);
    endtask

    initial begin
        int r;
        logic [11:0] e;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 12'd0);
        model_reset();
        #12;
        check_zero("reset");
        rst = 1'b0;

        // Alignment: large error keeps spinning, small negative error starts the ramp.
        apply(1, 0, 0, 12'd0);
        check("align_moving", 32'(bus0.moving), 32'd1);
        for (int k = 0; k < 5; k++) apply(0, 0, 1, 12'd100);
        check("align_frwrd", 32'(bus0.frwrd), 32'd0);
        apply(0, 0, 1, -12'sd10);
        check("align_exit_frwrd", 32'(bus0.frwrd), 32'd0);

        // Ramp to the cap; the 0x305 instance needs one extra sample to saturate.
        for (int k = 1; k <= 52; k++) begin
            apply(0, 0, 1, 12'd0);
            if (k == 1)  check("ramp_first", 32'(bus0.frwrd), 32'h010);
            if (k == 48) check("ramp_cap0",  32'(bus0.frwrd), 32'h300);
            if (k == 48) check("ramp_pre1",  32'(bus1.frwrd), 32'h300);
        end
        check("cruise0", 32'(bus0.frwrd), 32'h300);
        check("cruise1", 32'(bus1.frwrd), 32'h305);

        // move_go in CRUISE and RAMP_DN is dropped; drain down to IDLE.
        apply(1, 0, 1, 12'd0);
        apply(0, 1, 0, 12'd0);
        apply(1, 0, 0, 12'd0);
        for (int k = 0; k < 30; k++) apply(0, 0, 1, 12'd0);
        check("drained_busy", 32'(bus0.busy), 32'd0);

        // move_stop in IDLE ignored, err_vld masked while not moving.
        apply(0, 1, 1, 12'd0);
        check("idle_err_vld", 32'(bus0.err_vld), 32'd0);

        // go+stop together from IDLE goes to ALIGN; magnitude threshold boundaries.
        apply(1, 1, 0, 12'd0);
        apply(0, 0, 1, 12'h800);
        apply(0, 0, 1, 12'd32);
        apply(0, 0, 1, -12'sd32);
        check("thr_still_align", 32'(bus0.frwrd), 32'd0);
        apply(0, 0, 1, -12'sd31);
        for (int k = 0; k < 5; k++) apply(0, 0, 1, 12'd5);
        check("pre_stop", 32'(bus0.frwrd), 32'h050);

        // Stop and sample in the same cycle: frwrd holds, then steps down.
        apply(0, 1, 1, 12'd0);
        check("stop_hold", 32'(bus0.frwrd), 32'h050);
        apply(0, 0, 1, 12'd0);
        check("dn_1", 32'(bus0.frwrd), 32'h030);
        apply(0, 0, 1, 12'd0);
        check("dn_2", 32'(bus0.frwrd), 32'h010);
        apply(0, 0, 1, 12'd0);
        check("dn_3", 32'(bus0.frwrd), 32'h000);
        apply(0, 0, 0, 12'd0);
        check("done_pulse", 32'(bus0.done), 32'd1);
        apply(0, 0, 0, 12'd0);
        check("done_clear", 32'(bus0.done), 32'd0);

        // Asynchronous reset in the middle of CRUISE.
        apply(1, 0, 0, 12'd0);
        for (int k = 0; k < 55; k++) apply(0, 0, 1, 12'd0);
        check("pre_rst_cruise", 32'(bus0.frwrd), 32'h300);
        drive(1'b0, 1'b0, 1'b0, 12'd0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_zero("async_rst");
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Random traffic: rare go/stop, frequent samples, mostly small errors.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) e = 12'($urandom);
            else begin
                r = int'($urandom_range(0, 80)) - 40;
                e = 12'(r);
            end
            apply($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 1) == 1, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
